mem_sync: RTL and testbench

MEM_SYNC -- requirements
Module: mem_sync

---
 rtl/mem_sync.sv | 113 +++++++++++
 tb/tb_mem_sync.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync.sv
// Synchronous word memory behind a req/ack handshake with programmable wait states.
// Access completes WAIT_STATES cycles after acceptance; busy blocks new requests until ack.
module mem_sync #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 65536,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_INI = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              oor_q;
  logic              accept, commit;
  logic              op_we, op_in_range;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [IDX_W-1:0]  op_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = (state == IDLE) && req;

  // With no wait states the commit happens on the accepting edge, so the
  // operands come straight from the inputs being captured on that edge.
  assign op_we       = (state == IDLE) ? we    : we_q;
  assign op_addr     = (state == IDLE) ? addr  : addr_q;
  assign op_wdata    = (state == IDLE) ? wdata : wdata_q;
  assign op_in_range = {1'b0, op_addr} < DEPTH_L;
  assign op_idx      = op_addr[IDX_W-1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = DONE;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INI;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (commit) begin
        oor_q <= !op_in_range;
        if (!op_we) rdata <= op_in_range ? mem[op_idx] : '0;
      end
    end
  end

  // Storage is never reset; a reset coinciding with the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (commit && op_we && op_in_range && !reset) mem[op_idx] <= op_wdata;
  end

  assign ack  = (state == DONE);
  assign busy = (state != IDLE);
  assign err  = ack && oor_q;

endmodule

// File: tb/tb_mem_sync.sv
// Two instances (2 wait states / 256 words, 0 wait states / full space) share data inputs;
// a scoreboard per instance is filled at issue time and drained by an ack monitor.
module tb_mem_sync;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata_a, rdata_b;
  logic        ack_a, ack_b, busy_a, busy_b, err_a, err_b;

  always #5 clk = ~clk;

  mem_sync #(.DATA_W(8), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(2)) u_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .err(err_a));

  mem_sync #(.DATA_W(8), .ADDR_W(16), .DEPTH(65536), .WAIT_STATES(0)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .err(err_b));

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         exp_cyc;
  } exp_t;

  exp_t       qa[$], qb[$];
  logic [7:0] ma [256];
  logic [7:0] mb [int];
  logic [7:0] last_a = 8'h00, last_b = 8'h00;
  int         cyc = 0;
  int         total = 0, bad = 0;
  logic       prev_ack_a = 1'b0, prev_ack_b = 1'b0;
  logic [15:0] set_s [12] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                              16'h0006, 16'h0007, 16'h0010, 16'h0020, 16'h0100, 16'h0101};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain memory semantics, out-of-range only for the 256-word instance.
  task automatic model_a(input logic w, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    logic oor;
    oor = (a >= 16'd256);
    if (w) begin
      if (!oor) ma[a[7:0]] = d;
    end else begin
      last_a = oor ? 8'h00 : ma[a[7:0]];
    end
    e.rdata = last_a; e.err = oor; e.exp_cyc = cyc + 3;
    qa.push_back(e);
  endtask

  task automatic model_b(input logic w, input logic [15:0] a, input logic [7:0] d, input int lat);
    exp_t e;
    if (w) mb[int'(a)] = d;
    else   last_b = mb[int'(a)];
    e.rdata = last_b; e.err = 1'b0; e.exp_cyc = cyc + lat;
    qb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy_a && !busy_b) break;
    end
    chk("idle_after_access", {busy_a, busy_b}, 2'b00);
  endtask

  // Called at a negedge; scrambles the data inputs while the access is pending.
  task automatic issue(input logic ena, input logic enb, input logic w,
                       input logic [15:0] a, input logic [7:0] d);
    we = w; addr = a; wdata = d; req_a = ena; req_b = enb;
    if (ena) model_a(w, a, d);
    if (enb) model_b(w, a, d, 1);
    @(posedge clk);
    #1;
    req_b = 1'b0;
    req_a = ena & 1'($urandom);
    we = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
    if (ena) chk("busy_a_after_accept", busy_a, 1'b1);
    if (enb) chk("busy_b_after_accept", busy_b, 1'b1);
    @(negedge clk);
    req_a = 1'b0;
    if (ena) chk("busy_a_in_wait", busy_a, 1'b1);
    wait_idle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (prev_ack_a) begin
        chk("a_ack_one_cycle", ack_a, 1'b0);
        chk("a_busy_drop", busy_a, 1'b0);
      end
      if (prev_ack_b) chk("b_ack_one_cycle_busy_drop", {ack_b, busy_b}, 2'b00);
      if (ack_a) begin
        if (qa.size() == 0) chk("a_spurious_ack", ack_a, 1'b0);
        else begin
          e = qa.pop_front();
          chk("a_rdata", rdata_a, e.rdata);
          chk("a_err", err_a, e.err);
          chk("a_latency", cyc, e.exp_cyc);
          chk("a_busy_at_ack", busy_a, 1'b1);
        end
      end else if (qa.size() != 0 && cyc > qa[0].exp_cyc) begin
        chk("a_missing_ack", ack_a, 1'b1);
        void'(qa.pop_front());
      end
      if (ack_b) begin
        if (qb.size() == 0) chk("b_spurious_ack", ack_b, 1'b0);
        else begin
          e = qb.pop_front();
          chk("b_rdata", rdata_b, e.rdata);
          chk("b_err", err_b, e.err);
          chk("b_latency", cyc, e.exp_cyc);
        end
      end else if (qb.size() != 0 && cyc > qb[0].exp_cyc) begin
        chk("b_missing_ack", ack_b, 1'b1);
        void'(qb.pop_front());
      end
      prev_ack_a <= ack_a;
      prev_ack_b <= ack_b;
    end else begin
      prev_ack_a <= 1'b0;
      prev_ack_b <= 1'b0;
    end
  end

  initial begin
    int c0;
    logic [15:0] a;
    logic [7:0]  d;
    logic        w, ea, eb;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_a_outputs", {ack_a, busy_a, err_a, rdata_a}, 11'd0);
    chk("rst_b_outputs", {ack_b, busy_b, err_b, rdata_b}, 11'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Accepted on the first edge after reset release; then read back and hold
    issue(1, 1, 1, 16'h0010, 8'h2F);
    issue(1, 1, 0, 16'h0010, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("a_rdata_hold", rdata_a, 8'h2F);
      chk("b_rdata_hold", rdata_b, 8'h2F);
    end

    foreach (set_s[i]) begin
      d = (set_s[i] == 16'h0020) ? 8'h3C : 8'($urandom);
      issue(1, 1, 1, set_s[i], d);
    end

    // Out-of-range on the 256-word instance
    issue(1, 1, 1, 16'h0100, 8'hAA);
    issue(1, 1, 0, 16'h0100, 8'h00);
    issue(1, 1, 0, 16'h0000, 8'h00);

    // Zero-wait instance with req held high: acks every second cycle
    issue(1, 1, 1, 16'h0000, 8'h01);
    issue(1, 1, 1, 16'h0001, 8'h1F);
    c0 = cyc;
    we = 1'b0; addr = 16'h0000; req_b = 1'b1;
    model_b(0, 16'h0000, 8'h00, 1);
    @(posedge clk);
    #1 addr = 16'h0001;
    model_b(0, 16'h0001, 8'h00, 2);
    @(posedge clk);
    @(posedge clk);
    #1 req_b = 1'b0;
    chk("b_held_req_two_accesses", cyc - c0, 3);
    wait_idle();

    // Reset in the wait phase discards the pending write
    we = 1'b1; addr = 16'h0020; wdata = 8'h55; req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_a_outputs", {ack_a, busy_a, err_a, rdata_a}, 11'd0);
    chk("abort_b_rdata", rdata_b, 8'h00);
    last_a = 8'h00; last_b = 8'h00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue(1, 0, 0, 16'h0020, 8'h00);

    for (int n = 0; n < 150; n++) begin
      a  = set_s[$urandom_range(0, 11)];
      d  = 8'($urandom);
      w  = 1'($urandom);
      ea = 1'($urandom);
      eb = ea ? 1'($urandom) : 1'b1;
      issue(ea, eb, w, a, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int i = 0; i < 50 && (qa.size() + qb.size()) != 0; i++) @(negedge clk);
    chk("scoreboard_drained", qa.size() + qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
